// File: rtl/ecg_stream_pkg.sv
// ecg_stream_pkg: shared state encoding and sizing constants for the ECG sample streamer.
package ecg_stream_pkg;
   typedef enum logic [1:0] {IDLE, PLAY, FLUSH, DRAIN} state_t;
   localparam int DATA_W_DEF = 16;
   localparam int FLUSH_LEN_ORD8 = 8;
   localparam int FLUSH_LEN_ORD16 = 16;
   localparam int FLUSH_LEN_ORD32 = 32;
endpackage

// File: rtl/ecg_sample_streamer_if.sv
// ecg_sample_streamer_if: host load/readback port and FIR sample/response stream.
interface ecg_sample_streamer_if
   import ecg_stream_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = 10
);
   logic              ld_en;
   logic [ADDR_W-1:0] ld_addr;
   logic [DATA_W-1:0] ld_data;
   logic [ADDR_W:0]   cap_addr;
   logic [DATA_W-1:0] cap_data;
   logic [ADDR_W:0]   cap_count;
   logic [DATA_W-1:0] sample_out;
   logic              sample_valid;
   logic [DATA_W-1:0] fir_out;
   modport master (
      output ld_en, ld_addr, ld_data, cap_addr, fir_out,
      input  cap_data, cap_count, sample_out, sample_valid
   );
   modport slave (
      input  ld_en, ld_addr, ld_data, cap_addr, fir_out,
      output cap_data, cap_count, sample_out, sample_valid
   );
endinterface

// File: rtl/ecg_sample_ram.sv
// ecg_sample_ram: simple dual-port RAM, one write port and one registered read port.
module ecg_sample_ram #(
   parameter int W = 16,
   parameter int A = 10
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         we,
   input  logic [A-1:0] waddr,
   input  logic [W-1:0] wdata,
   input  logic [A-1:0] raddr,
   output logic [W-1:0] rdata
);
   logic [W-1:0] mem [2**A];
   always_ff @(posedge clk)
      if (we) mem[waddr] <= wdata;
   always_ff @(posedge clk or negedge reset)
      if (!reset) rdata <= '0;
      else rdata <= mem[raddr];
endmodule

// File: rtl/ecg_sample_streamer.sv
// ecg_sample_streamer: plays a preloaded sample buffer into a FIR core at a fixed interval,
// drains the filter with zeros and captures every response for host readback.
module ecg_sample_streamer
   import ecg_stream_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = 10,
   parameter int FLUSH_LEN = FLUSH_LEN_ORD32,
   parameter int SAMPLE_DIV = 2,
   parameter int FIR_LAT = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [ADDR_W:0]      sample_count,
   output logic                 busy,
   output logic                 done,
   ecg_sample_streamer_if.slave bus
);
   localparam int PW = ADDR_W + 1;
   localparam int DIV_W = SAMPLE_DIV > 1 ? $clog2(SAMPLE_DIV) : 1;
   localparam logic [PW-1:0] DEPTH = PW'(2 ** ADDR_W);
   localparam logic [PW-1:0] FL_LAST = PW'(FLUSH_LEN - 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
   state_t state, next;
   logic [PW-1:0] ptr, ptr_next, cnt, cnt_in, cap_cnt;
   logic [DIV_W-1:0] div;
   logic [FIR_LAT-1:0] dl, dl_low;
   logic [DATA_W-1:0] sample_q, smp_rd, cap_rd;
   logic valid_q, done_q, go, run, tick, drained, cap_we;
   assign cnt_in = sample_count > DEPTH ? DEPTH : sample_count;
   assign go = state == IDLE && start;
   assign run = state == PLAY || state == FLUSH;
   assign tick = run && div == DIV_LAST;
   assign dl_low = dl << 1;
   // leave DRAIN on the cycle the final response is being written, so done and cap_count agree
   assign drained = !valid_q && dl_low == '0;
   assign cap_we = dl[FIR_LAT-1];
   assign busy = state != IDLE;
   assign done = done_q;
   assign bus.sample_out = sample_q;
   assign bus.sample_valid = valid_q;
   assign bus.cap_data = cap_rd;
   assign bus.cap_count = cap_cnt;
   always_comb begin
      next = state;
      ptr_next = ptr;
      unique case (state)
         IDLE: begin
            next = start ? (cnt_in == '0 ? FLUSH : PLAY) : IDLE;
            ptr_next = start ? '0 : ptr;
         end
         PLAY: begin
            next = tick && ptr == cnt - 1'b1 ? FLUSH : PLAY;
            ptr_next = !tick ? ptr : ptr == cnt - 1'b1 ? '0 : ptr + 1'b1;
         end
         FLUSH: begin
            next = tick && ptr == FL_LAST ? DRAIN : FLUSH;
            ptr_next = tick ? ptr + 1'b1 : ptr;
         end
         DRAIN: next = drained ? IDLE : DRAIN;
         default: next = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state <= IDLE;
         ptr <= '0;
         cnt <= '0;
         div <= '0;
         dl <= '0;
         sample_q <= '0;
         valid_q <= 1'b0;
         done_q <= 1'b0;
         cap_cnt <= '0;
      end else begin
         state <= next;
         ptr <= ptr_next;
         valid_q <= tick;
         done_q <= state == DRAIN && next == IDLE;
         dl <= dl_low | FIR_LAT'(valid_q);
         // preloading the terminal count forces the first tick right after leaving IDLE
         if (go) begin
            cnt <= cnt_in;
            div <= DIV_LAST;
         end else if (run) div <= tick ? '0 : div + 1'b1;
         if (tick) sample_q <= state == PLAY ? smp_rd : '0;
         if (go) cap_cnt <= '0;
         else if (cap_we) cap_cnt <= cap_cnt + 1'b1;
      end
   // read address runs on the next pointer so the word is ready on the tick that consumes it
   ecg_sample_ram #(.W(DATA_W), .A(ADDR_W)) u_sample_ram (
      .clk   (clk),
      .reset (reset),
      .we    (bus.ld_en && state == IDLE),
      .waddr (bus.ld_addr),
      .wdata (bus.ld_data),
      .raddr (ptr_next[ADDR_W-1:0]),
      .rdata (smp_rd)
   );
   ecg_sample_ram #(.W(DATA_W), .A(PW)) u_cap_ram (
      .clk   (clk),
      .reset (reset),
      .we    (cap_we),
      .waddr (cap_cnt),
      .wdata (bus.fir_out),
      .raddr (bus.cap_addr),
      .rdata (cap_rd)
   );
endmodule

// File: doc/ecg_sample_streamer.md
# ecg_sample_streamer

Hardware replacement for the file-driven stimulus/capture loop around the FIR filters. It plays a preloaded ECG sample buffer into a FIR core at a fixed sample interval, then appends (FLUSH_LEN) zero samples to drain the filter. It captures the FIR response into an on-chip buffer that a host reads back. It sits between the host load/readback port and any `fir_*` core (`data_in`/`filtered_output`).

## Interface
Parameters:
- DATA_W, 16, sample width (signed)
- ADDR_W, 10, sample buffer address width; DEPTH = 2**ADDR_W
- FLUSH_LEN, 32, zero samples appended after the last real sample (FILTER_TAPS-1); must be ≤ DEPTH
- SAMPLE_DIV, 2, clocks per sample, ≥ 1
- FIR_LAT, 2, clocks from a sample on `sample_out` to its valid response on `fir_out`, ≥ 1

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low
- start  in  1  level; sampled only in IDLE
- sample_count  in  ADDR_W+1  real samples to play; values > DEPTH clamp to DEPTH
- ld_en  in  1  sample buffer write enable
- ld_addr  in  ADDR_W  sample buffer write address
- ld_data  in  DATA_W  sample buffer write data
- sample_out  out  DATA_W  signed sample to FIR `data_in`
- sample_valid  out  1  one-cycle strobe when `sample_out` changes to a new sample
- fir_out  in  DATA_W  signed FIR `filtered_output`
- cap_addr  in  ADDR_W+1  capture buffer read address
- cap_data  out  DATA_W  capture buffer read data, registered (1-cycle latency)
- cap_count  out  ADDR_W+1  responses captured this run
- busy  out  1  high in PLAY/FLUSH/DRAIN
- done  out  1  one-cycle pulse on entry to IDLE from DRAIN

## Operation
- FSM states: IDLE, PLAY, FLUSH, DRAIN.
- IDLE → PLAY on `start`=1. If the clamped count is 0, go IDLE → FLUSH. On the start transition, clear `cap_count` and the read/write pointers.
- Divider: counts 0..SAMPLE_DIV-1 while busy. Its terminal count is the strobe `tick`. The first tick is forced on the cycle after leaving IDLE.
- PLAY: each tick loads `sample_out` ← buf[rd_ptr], pulses `sample_valid`, and increments rd_ptr. After the tick that issues sample count-1, go to FLUSH.
- FLUSH: each tick loads `sample_out` ← 0 and pulses `sample_valid`. After FLUSH_LEN ticks, go to DRAIN.
- DRAIN: no new ticks. `sample_out` holds 0. When the valid delay line is empty, go to IDLE and pulse `done`.
- Capture: `sample_valid` feeds a FIR_LAT-deep shift register. When its output is 1, write cap_buf[cap_count] ← `fir_out` and increment `cap_count`.
- Final `cap_count` = clamped count + FLUSH_LEN. The capture buffer holds 2**(ADDR_W+1) entries, so it never wraps.
- Between strobes `sample_out` holds its value (zero-order hold).
- `ld_en` is ignored while `busy`. The load and capture-read ports work in IDLE.
- `start` is ignored while busy. `start` still high in IDLE after `done` begins a new run.
- Reset (asserted at any time, including mid-run):
  - all outputs go to 0 and the FSM returns to IDLE;
  - the divider, pointers and delay line clear;
  - buffer contents are not reset.

## Timing
- Reset values: `sample_out`=0, `sample_valid`=0, `cap_data`=0, `cap_count`=0, `busy`=0, `done`=0.
- `start` seen at edge N → `busy` and the first `sample_valid` are high after edge N+1.
- Successive strobes are SAMPLE_DIV cycles apart, with no gap between PLAY and FLUSH.
- The response to the strobe at edge M is captured at edge M+FIR_LAT.
- `done` occurs FIR_LAT+1 cycles after the last FLUSH strobe.
- Total run length ≈ (count+FLUSH_LEN)·SAMPLE_DIV + FIR_LAT + 1 cycles.
- `cap_data` reflects `cap_addr` one cycle later.
- All arithmetic is unsigned on pointers. Sample data passes through bit-exact, with no sign manipulation.

## Structure
- Shared package `ecg_stream_pkg`: the state enum (IDLE/PLAY/FLUSH/DRAIN), the default DATA_W, and the FLUSH_LEN constants for the 8/16/32 filter orders.
- One sub-module `ecg_sample_ram`: a simple dual-port RAM (one write port, one registered read port). It is instantiated twice, for the sample buffer and the capture buffer.
- The FSM, divider and delay line live in the top level.

## Test plan
- Load buf[0..3] = 0x0010, 0xFFF0, 0x7FFF, 0x8000 with count 4, FLUSH_LEN 32, SAMPLE_DIV 2:
  - exactly 36 `sample_valid` pulses, 2 cycles apart;
  - the first 4 values match the buffer and the remaining 32 are 0;
  - `done` fires once and `cap_count`=36.
- Feed `fir_out` from an identity stub with FIR_LAT=2 → cap_buf[0..3] equals the loaded samples and cap_buf[4..35]=0.
- Count 0 → 32 zero strobes, then `done` with `cap_count`=32.
- Count 2000 with ADDR_W=10 → clamps to 1024 and `cap_count`=1056.
- Assert reset mid-PLAY:
  - all outputs are 0 and the FSM is in IDLE;
  - buffer contents are intact;
  - a restart reproduces the full run from sample 0.
- `ld_en` pulsed during PLAY → sample buffer unchanged. `start` held high → `busy` stays 1 and the next run begins after `done`.
